// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared geometry and saturation helpers for pipelined_addsub
//
// Contents:
//   MAX_W        widest operand the saturation helpers can describe
//   chunk_width  bits resolved per pipeline stage (W / STAGES)
//   geometry_ok  elaboration check: 1 <= STAGES <= W and W % STAGES == 0
//   sat_pos      most positive W-bit signed value, 0x7F..F (zero-extended to MAX_W)
//   sat_neg      most negative W-bit signed value, 0x80..0 (zero-extended to MAX_W)
package addsub_pkg;

  localparam int MAX_W = 1024;

  function automatic int chunk_width(input int w, input int stages);
    return w / stages;
  endfunction

  function automatic bit geometry_ok(input int w, input int stages);
    return (stages >= 1) && (stages <= w) && ((w % stages) == 0);
  endfunction

  function automatic logic [MAX_W-1:0] sat_pos(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < w - 1; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_W-1:0] sat_neg(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational C-bit full-add slice
//
// Ports:
//   a, b   in  C  operand chunks (b already conditioned for subtract)
//   ci     in  1  carry into bit 0 of the chunk
//   s      out C  chunk sum
//   co     out 1  carry out of the chunk MSB
//   cmsb   out 1  carry into the chunk MSB (used for signed overflow)
module addsub_chunk #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         ci,
  output logic [C-1:0] s,
  output logic         co,
  output logic         cmsb
);

  logic [C:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, ci};
  assign s    = full[C-1:0];
  assign co   = full[C];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the sum.
  assign cmsb = full[C-1] ^ a[C-1] ^ b[C-1];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - STAGES-deep pipelined W-bit two's-complement adder/subtractor
//
// Ports:
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   in_valid   in  1  operation offered
//   in_ready   out 1  operation accepted when in_valid && in_ready
//   a, b       in  W  operands
//   cin        in  1  carry-in (add) / not-borrow-in (sub)
//   sub        in  1  0: y = a + b + cin, 1: y = a + ~b + cin
//   out_valid  out 1  result present
//   out_ready  in  1  result taken when out_valid && out_ready
//   y          out W  result
//   cout       out 1  carry out of bit W-1
//   ovf        out 1  signed overflow
//
// Build option: define ADDSUB_SAT_EN to saturate y on signed overflow.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int W      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         cout,
  output logic         ovf
);

  localparam int C    = chunk_width(W, STAGES);
  localparam int LAST = STAGES - 1;

  if (!geometry_ok(W, STAGES)) begin : g_bad_geometry
    $error("pipelined_addsub: need 1 <= STAGES <= W and W a multiple of STAGES");
  end

  // Stage registers. r_sum holds only the chunks resolved so far (upper bits 0);
  // r_a/r_b keep the raw operands so later stages can pick their chunk.
  logic [STAGES-1:0] r_valid;
  logic              r_carry [STAGES];
  logic [W-1:0]      r_sum   [STAGES];
  logic [W-1:0]      r_a     [STAGES];
  logic [W-1:0]      r_b     [STAGES];
  logic              r_sub   [STAGES];
  logic              r_amsb  [STAGES];
  logic              r_cmsb  [STAGES];

  logic [STAGES-1:0] nxt_valid;
  logic              nxt_carry [STAGES];
  logic [W-1:0]      nxt_sum   [STAGES];
  logic [W-1:0]      nxt_a     [STAGES];
  logic [W-1:0]      nxt_b     [STAGES];
  logic              nxt_sub   [STAGES];
  logic              nxt_amsb  [STAGES];
  logic              nxt_cmsb  [STAGES];

  logic [STAGES-1:0] ld;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W-1:0] pa, pb, psum;
    logic         psub, pci, pamsb, pcmsb, pvalid;
    logic [C-1:0] ca, cb, s;
    logic         co, cm;

    if (k == 0) begin : g_src_in
      assign pvalid = in_valid;
      assign pa     = a;
      assign pb     = b;
      assign psub   = sub;
      assign pci    = cin;
      assign psum   = '0;
      assign pamsb  = a[W-1];
      assign pcmsb  = 1'b0;
    end else begin : g_src_reg
      assign pvalid = r_valid[k-1];
      assign pa     = r_a[k-1];
      assign pb     = r_b[k-1];
      assign psub   = r_sub[k-1];
      assign pci    = r_carry[k-1];
      assign psum   = r_sum[k-1];
      assign pamsb  = r_amsb[k-1];
      assign pcmsb  = r_cmsb[k-1];
    end

    assign ca = pa[k*C +: C];
    assign cb = pb[k*C +: C] ^ {C{psub}};

    addsub_chunk #(.C(C)) u_chunk (
      .a    (ca),
      .b    (cb),
      .ci   (pci),
      .s    (s),
      .co   (co),
      .cmsb (cm)
    );

    assign nxt_valid[k] = pvalid;
    assign nxt_carry[k] = co;
    assign nxt_sum[k]   = psum | (W'(s) << (k * C));
    assign nxt_a[k]     = pa;
    assign nxt_b[k]     = pb;
    assign nxt_sub[k]   = psub;
    assign nxt_amsb[k]  = pamsb;
    // Only the top chunk contains bit W-1, so only it knows the carry into it.
    assign nxt_cmsb[k]  = (k == LAST) ? cm : pcmsb;
  end

  // Stage k can load if it is empty or its content moves on this cycle;
  // the ripple runs from out_ready back to stage 0 with no skid buffer.
  always_comb begin
    logic acc;
    ld  = '0;
    acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc   = !r_valid[k] || acc;
      ld[k] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_carry[k] <= 1'b0;
        r_sum[k]   <= '0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sub[k]   <= 1'b0;
        r_amsb[k]  <= 1'b0;
        r_cmsb[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          r_valid[k] <= nxt_valid[k];
          // Data only moves with a real operation so idle stages stay quiet.
          if (nxt_valid[k]) begin
            r_carry[k] <= nxt_carry[k];
            r_sum[k]   <= nxt_sum[k];
            r_a[k]     <= nxt_a[k];
            r_b[k]     <= nxt_b[k];
            r_sub[k]   <= nxt_sub[k];
            r_amsb[k]  <= nxt_amsb[k];
            r_cmsb[k]  <= nxt_cmsb[k];
          end
        end
      end
    end
  end

  assign in_ready  = ld[0] && !rst;
  assign out_valid = r_valid[LAST];
  assign cout      = r_carry[LAST];
  assign ovf       = r_cmsb[LAST] ^ r_carry[LAST];

`ifdef ADDSUB_SAT_EN
  localparam logic [MAX_W-1:0] SAT_POS_FULL = sat_pos(W);
  localparam logic [MAX_W-1:0] SAT_NEG_FULL = sat_neg(W);
  localparam logic [W-1:0]     SAT_POS      = SAT_POS_FULL[W-1:0];
  localparam logic [W-1:0]     SAT_NEG      = SAT_NEG_FULL[W-1:0];

  // Overflow means both operands shared a[W-1]'s sign, so it picks the rail.
  assign y = ovf ? (r_amsb[LAST] ? SAT_NEG : SAT_POS) : r_sum[LAST];
`else
  assign y = r_sum[LAST];
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub (W=16, STAGES=4)
module tb_pipelined_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        cout;
  logic        ovf;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops   = 0;
  logic [17:0] exp_q[$];
  logic        stalled_prev = 1'b0;
  logic [17:0] held = '0;

  pipelined_addsub #(.W(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, y} from plain wide arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                        input logic icin, input logic isub);
    logic [15:0] bb;
    logic [16:0] full;
    logic [15:0] low;
    logic        o;
    logic [15:0] r;
    bb   = isub ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, bb} + {16'd0, icin};
    low  = {1'b0, ia[14:0]} + {1'b0, bb[14:0]} + {15'd0, icin};
    o    = low[15] ^ full[16];
    r    = full[15:0];
`ifdef ADDSUB_SAT_EN
    if (o) r = ia[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, full[16], r};
  endfunction

  // One clock cycle: drive, sample mid-cycle, score, then advance past the edge.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic icin, input logic isub, input logic ior, output logic acc);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = ior;
    #1;
    if (stalled_prev) check("hold", 32'({ovf, cout, y}), 32'(held));
    acc = iv && in_ready;
    if (acc) exp_q.push_back(model(ia, ib, icin, isub));
    if (out_valid && out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) check("spurious_result", 32'(out_valid), 32'd0);
      else check("result", 32'({ovf, cout, y}), 32'(exp_q.pop_front()));
    end
    stalled_prev = out_valid && !out_ready;
    held         = {ovf, cout, y};
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                            input logic icin, input logic isub,
                            input logic [15:0] ey, input logic ec, input logic eo);
    logic acc;
    int   n;
    cycle(1'b1, ia, ib, icin, isub, 1'b1, acc);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    n = 1;
    while (!out_valid && n < 12) begin
      cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic        acc;
    logic        v, rc, rs, ro;
    logic [15:0] ra, rb;
    logic [15:0] ba [10];
    logic [15:0] bb [10];
    logic        bc [10];
    logic        bs [10];
    int          i, idx, start, sent, stale;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    run_single("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    run_single("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
    run_single("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    run_single("sub_cin1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_single("sub_cin0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0);

    // Back-pressure: 10 ops back-to-back, consumer stalled for 8 cycles.
    for (int k = 0; k < 10; k++) begin
      ba[k] = 16'($urandom);
      bb[k] = 16'($urandom);
      bc[k] = 1'($urandom_range(1));
      bs[k] = 1'($urandom_range(1));
    end
    i = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, ba[i], bb[i], bc[i], bs[i], 1'b0, acc);
      if (acc) i++;
    end
    check("bp_accepts_while_stalled", 32'(i), 32'd4);
    start = n_pops;
    for (int c = 0; c < 100 && (i < 10 || exp_q.size() > 0); c++) begin
      idx = (i < 10) ? i : 0;
      cycle(i < 10, ba[idx], bb[idx], bc[idx], bs[idx], 1'b1, acc);
      if (acc) i++;
    end
    check("bp_results", 32'(n_pops - start), 32'd10);

    // Random streaming with random flow control on both sides.
    start = n_pops;
    sent  = 0;
    for (int c = 0; c < 60000 && (sent < 10000 || exp_q.size() > 0); c++) begin
      v  = (sent < 10000) && ($urandom_range(3) != 0);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1));
      rs = 1'($urandom_range(1));
      ro = ($urandom_range(3) != 0);
      cycle(v, ra, rb, rc, rs, ro, acc);
      if (acc) sent++;
    end
    check("rnd_results", 32'(n_pops - start), 32'd10000);

    // Reset with three operations in flight.
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, acc);
    end
    rst = 1'b1;
    cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, acc);
    check("accept_during_rst", 32'(acc), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    stalled_prev = 1'b0;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_y", 32'(y), 32'd0);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, acc);
      if (out_valid) stale++;
    end
    check("no_stale_result", 32'(stale), 32'd0);
    run_single("post_rst_op", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
